cache_ctrl: RTL

Sequencing controller for the 2-way set-associative data cache in the memory stage. It classifies each CPU memory request as read hit, read miss or write, and stalls the pipeline while main RAM is busy. It drives the RAM request/ack handshake and per-set LRU replacement, and generates the refill and invalidate strobes for the cache arrays. It also performs a whole-cache flush sweep and keeps hit/miss performance counters.

---
 rtl/cache_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 2-way set-associative data cache.
// It classifies CPU requests as read hit, read miss or store, and stalls the
// pipeline while RAM is busy. It drives the RAM request/ack handshake and the
// per-set LRU, generates the refill, update and invalidate strobes, runs the
// whole-cache flush sweep, and keeps saturating hit/miss counters.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cpu_req/we/addr       memory-stage request (load/store, byte address)
//   hit0, hit1            per-way tag match for cpu_addr
//   flush_req             level request to invalidate the whole cache
//   ram_ack               one-cycle completion pulse from RAM
//   stall                 pipeline freeze
//   ram_req/we/addr       RAM access, held stable until ram_ack
//   fill_en/way/set       refill strobe into the cache arrays
//   upd_en/way            store-data update of the hitting way
//   inval_en/set          clear both valid bits of one set
//   flush_done            pulse on the last flush cycle
//   hit_cnt, miss_cnt     saturating read hit/miss counters
//
// state  | meaning
// IDLE   | accept flush or CPU request; read hits served here without stall
// REFILL | read miss: fetch word-aligned line from RAM, fill the victim way
// WRITE  | store write-through to RAM; update the cache only on a store hit
// FLUSH  | invalidate one set per cycle and clear its LRU bit

module cache_ctrl #(
  parameter int SET_BITS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [31:0]         cpu_addr,
  input  logic                hit0,
  input  logic                hit1,
  input  logic                flush_req,
  input  logic                ram_ack,
  output logic                stall,
  output logic                ram_req,
  output logic                ram_we,
  output logic [31:0]         ram_addr,
  output logic                fill_en,
  output logic                fill_way,
  output logic [SET_BITS-1:0] fill_set,
  output logic                upd_en,
  output logic                upd_way,
  output logic                inval_en,
  output logic [SET_BITS-1:0] inval_set,
  output logic                flush_done,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int NSETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [SET_BITS-1:0] set_q, set_d;
  logic [SET_BITS-1:0] fcnt_q, fcnt_d;
  logic                way_q, way_d;       // refill victim or store hit way
  logic                hitc_q, hitc_d;     // store captured a hit
  logic [NSETS-1:0]    lru_q, lru_d;
  logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

  logic [SET_BITS-1:0] req_set;
  logic                any_hit;
  logic                hit_way;

  assign req_set = cpu_addr[SET_BITS+1:2];
  assign any_hit = hit0 | hit1;
  assign hit_way = ~hit0;                  // both hit resolves to way 0

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    set_d      = set_q;
    fcnt_d     = fcnt_q;
    way_d      = way_q;
    hitc_d     = hitc_q;
    lru_d      = lru_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    stall      = 1'b0;
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_q;
    fill_en    = 1'b0;
    fill_way   = way_q;
    fill_set   = set_q;
    upd_en     = 1'b0;
    upd_way    = way_q;
    inval_en   = 1'b0;
    inval_set  = fcnt_q;
    flush_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          stall   = 1'b1;
          fcnt_d  = '0;
          state_d = FLUSH;
        end else if (cpu_req) begin
          if (cpu_we) begin
            stall   = 1'b1;
            addr_d  = cpu_addr;
            set_d   = req_set;
            hitc_d  = any_hit;
            way_d   = hit_way;
            state_d = WRITE;
          end else if (any_hit) begin
            lru_d[req_set] = ~hit_way;
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            stall   = 1'b1;
            addr_d  = {cpu_addr[31:2], 2'b00};
            set_d   = req_set;
            way_d   = lru_q[req_set];
            if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + 1'b1;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall   = 1'b1;
        ram_req = 1'b1;
        if (ram_ack) begin
          fill_en      = 1'b1;
          lru_d[set_q] = ~way_q;
          state_d      = IDLE;
        end
      end
      WRITE: begin
        stall   = 1'b1;
        ram_req = 1'b1;
        ram_we  = 1'b1;
        if (ram_ack) begin
          upd_en  = hitc_q;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        stall         = 1'b1;
        inval_en      = 1'b1;
        lru_d[fcnt_q] = 1'b0;
        fcnt_d        = fcnt_q + 1'b1;
        if (fcnt_q == SET_BITS'(NSETS - 1)) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is asserted nothing may leak out of the comb decode,
    // otherwise an abandoned operation could still strobe the arrays.
    if (!rst_n) begin
      stall      = 1'b0;
      ram_req    = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      fill_en    = 1'b0;
      fill_way   = 1'b0;
      fill_set   = '0;
      upd_en     = 1'b0;
      upd_way    = 1'b0;
      inval_en   = 1'b0;
      inval_set  = '0;
      flush_done = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      set_q      <= '0;
      fcnt_q     <= '0;
      way_q      <= 1'b0;
      hitc_q     <= 1'b0;
      lru_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      set_q      <= set_d;
      fcnt_q     <= fcnt_d;
      way_q      <= way_d;
      hitc_q     <= hitc_d;
      lru_q      <= lru_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
